interrupt_controller: RTL and testbench

//  Collects NUM_SRC external interrupt lines and arbitrates them onto the single external

---
 rtl/interrupt_controller_pkg.sv | 29 ++
 rtl/irq_priority_encoder.sv | 19 +
 rtl/interrupt_controller.sv | 138 +++++++++++++
 tb/tb_interrupt_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM state codes
// and the ID-to-bitmask helper used when a claim clears its pending bit.
package interrupt_controller_pkg;

    localparam logic [1:0] IRQ_PENDING = 2'd0;
    localparam logic [1:0] IRQ_ENABLE  = 2'd1;
    localparam logic [1:0] IRQ_CLAIM   = 2'd2;
    localparam logic [1:0] IRQ_STATUS  = 2'd3;

    localparam int ID_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIGNAL  = 2'd1,
        ST_CLAIMED = 2'd2
    } irq_state_e;

    // ID 0 means "no source", so it maps to an empty mask.
    function automatic logic [31:0] id_to_mask(input logic [ID_W-1:0] id);
        logic [31:0] mask;
        if (id != 5'd0) begin
            mask = 32'd1 << (id - 5'd1);
        end else begin
            mask = 32'd0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest-index set bit of the masked pending vector wins.
module irq_priority_encoder #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] masked,
    output logic               valid,
    output logic [4:0]         winner_id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        winner_id = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            winner_id = masked[i] ? 5'(i + 1) : winner_id;
        end
        valid = |masked;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching interrupt controller with fixed priority and a claim/complete handshake
// feeding the privilege unit's external interrupt input.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [NUM_SRC-1:0] I_irq,
    input  logic               I_wen,
    input  logic               I_ren,
    input  logic [1:0]         I_addr,
    input  logic [31:0]        I_wdata,
    output logic [31:0]        O_rdata,
    output logic               O_extinterrupt
);

    logic [NUM_SRC-1:0] irq_q_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] enable_r;
    logic [ID_W-1:0]    claimed_id_r;
    irq_state_e         state_r;
    logic               ext_r;

    irq_state_e         state_s;
    logic [NUM_SRC-1:0] masked_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] pending_s;
    logic [31:0]        claim_mask_s;
    logic               win_valid_s;
    logic [ID_W-1:0]    win_id_s;
    logic               claim_s;
    logic               complete_s;
    logic               unused_s;

    irq_priority_encoder #(.NUM_SRC(NUM_SRC)) u_prio (
        .masked    (masked_s),
        .valid     (win_valid_s),
        .winner_id (win_id_s)
    );

    // Handshake decode; a simultaneous read on the claim port takes precedence over the write.
    always_comb begin
        masked_s     = pending_r & enable_r;
        rise_s       = I_irq & ~irq_q_r;
        claim_s      = I_ren && (I_addr == IRQ_CLAIM) && (state_r == ST_SIGNAL) && win_valid_s;
        complete_s   = I_wen && !I_ren && (I_addr == IRQ_CLAIM) && (state_r == ST_CLAIMED)
                       && (I_wdata[4:0] == claimed_id_r);
        claim_mask_s = id_to_mask(win_id_s);
        unused_s     = ^{I_wdata, claim_mask_s};
        if (claim_s) begin
            pending_s = (pending_r & ~claim_mask_s[NUM_SRC-1:0]) | rise_s;
        end else begin
            pending_s = pending_r | rise_s;
        end
    end

    // Next-state logic of the signalling FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (masked_s != '0) begin
                    state_s = ST_SIGNAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SIGNAL: begin
                if (claim_s) begin
                    state_s = ST_CLAIMED;
                end else if (masked_s == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SIGNAL;
                end
            end
            ST_CLAIMED: begin
                if (complete_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLAIMED;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Input history keeps tracking through reset so a line held high across reset is not seen as a new edge.
    always_ff @(posedge I_clk) begin
        irq_q_r <= I_irq;
    end

    // Pending, enable, claim bookkeeping, state and the registered interrupt output.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pending_r    <= '0;
            enable_r     <= '0;
            claimed_id_r <= 5'd0;
            state_r      <= ST_IDLE;
            ext_r        <= 1'b0;
        end else begin
            pending_r <= pending_s;
            if (I_wen && (I_addr == IRQ_ENABLE)) begin
                enable_r <= I_wdata[NUM_SRC-1:0];
            end
            if (claim_s) begin
                claimed_id_r <= win_id_s;
            end else if (complete_s) begin
                claimed_id_r <= 5'd0;
            end
            state_r <= state_s;
            ext_r   <= (state_s == ST_SIGNAL);
        end
    end

    assign O_extinterrupt = ext_r;

    // Read mux; the claim word is only meaningful while signalling.
    always_comb begin
        O_rdata = 32'd0;
        case (I_addr)
            IRQ_PENDING: O_rdata = {{(32-NUM_SRC){1'b0}}, pending_r};
            IRQ_ENABLE:  O_rdata = {{(32-NUM_SRC){1'b0}}, enable_r};
            IRQ_CLAIM: begin
                if (state_r == ST_SIGNAL) begin
                    O_rdata = {win_valid_s, 26'd0, win_id_s};
                end else begin
                    O_rdata = 32'd0;
                end
            end
            IRQ_STATUS:  O_rdata = {19'd0, claimed_id_r, 6'd0, state_r};
            default:     O_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a behavioural reference model checked every cycle.
module tb_interrupt_controller;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [7:0]  I_irq;
    logic        I_wen;
    logic        I_ren;
    logic [1:0]  I_addr;
    logic [31:0] I_wdata;
    logic [31:0] O_rdata;
    logic        O_extinterrupt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    interrupt_controller #(.NUM_SRC(8)) dut (
        .I_clk          (I_clk),
        .I_rst          (I_rst),
        .I_irq          (I_irq),
        .I_wen          (I_wen),
        .I_ren          (I_ren),
        .I_addr         (I_addr),
        .I_wdata        (I_wdata),
        .O_rdata        (O_rdata),
        .O_extinterrupt (O_extinterrupt)
    );

    always #5 I_clk = ~I_clk;

    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] en;
        logic [7:0] prev;
        logic [1:0] st;   // 0 idle, 1 signalling, 2 claimed
        logic [4:0] cid;
    } mdl_t;

    mdl_t m;

    function automatic int lowest_id(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input logic rst, input logic [7:0] irq,
                                        input logic wen, input logic ren, input logic [1:0] addr,
                                        input logic [31:0] wdata);
        mdl_t n;
        int   w;
        bit   claim;
        bit   done;
        n = c;
        n.prev = irq;
        if (rst) begin
            n.pend = 8'd0; n.en = 8'd0; n.st = 2'd0; n.cid = 5'd0;
            return n;
        end
        w     = lowest_id(c.pend & c.en);
        claim = ren && addr == 2'd2 && c.st == 2'd1 && w != 0;
        done  = wen && !ren && addr == 2'd2 && c.st == 2'd2 && wdata[4:0] == c.cid;
        if (claim) n.pend[w-1] = 1'b0;
        n.pend = n.pend | (irq & ~c.prev);
        if (wen && addr == 2'd1) n.en = wdata[7:0];
        if (c.st == 2'd0 && (c.pend & c.en) != 8'd0) n.st = 2'd1;
        if (c.st == 2'd1) begin
            if (claim) begin
                n.st = 2'd2; n.cid = 5'(w);
            end else if ((c.pend & c.en) == 8'd0) begin
                n.st = 2'd0;
            end
        end
        if (c.st == 2'd2 && done) begin
            n.st = 2'd0; n.cid = 5'd0;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_rdata(input mdl_t c, input logic [1:0] addr);
        int w;
        w = lowest_id(c.pend & c.en);
        case (addr)
            2'd0: return {24'd0, c.pend};
            2'd1: return {24'd0, c.en};
            2'd2: return (c.st == 2'd1 && w != 0) ? (32'h8000_0000 | 32'(w)) : 32'd0;
            default: return {19'd0, c.cid, 6'd0, c.st};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model advances on the same edge as the DUT.
    always @(posedge I_clk) begin
        m <= model_next(m, I_rst, I_irq, I_wen, I_ren, I_addr, I_wdata);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge I_clk) begin
        if (chk_en) begin
            chk("model_ext", {31'd0, O_extinterrupt}, {31'd0, (m.st == 2'd1)});
            chk("model_rdata", O_rdata, model_rdata(m, I_addr));
        end
    end

    task automatic tick();
        @(posedge I_clk);
        #2;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        I_addr = a; I_ren = 1'b1;
        #1 chk(nm, O_rdata, exp);
        tick();
        I_ren = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        I_addr = a; I_wdata = d; I_wen = 1'b1;
        tick();
        I_wen = 1'b0;
    endtask

    task automatic expect_ext(input logic e, input string nm);
        #1 chk(nm, {31'd0, O_extinterrupt}, {31'd0, e});
    endtask

    initial begin
        I_rst = 1'b1; I_irq = 8'd0; I_wen = 1'b0; I_ren = 1'b0; I_addr = 2'd0; I_wdata = 32'd0;
        tick(); tick();
        chk_en = 1'b1;
        I_rst = 1'b0;

        // 1: reset state
        expect_ext(1'b0, "rst_ext");
        rd(2'd0, 32'd0, "rst_pending");
        rd(2'd1, 32'd0, "rst_enable");
        rd(2'd3, 32'd0, "rst_status");
        rd(2'd2, 32'd0, "rst_claim");

        // 2: single source, two-edge latency, claim and complete
        wr(2'd1, 32'h04);
        I_irq = 8'h04; tick(); I_irq = 8'h00;
        expect_ext(1'b0, "lat_edge_k");
        tick();
        expect_ext(1'b1, "lat_edge_k1");
        rd(2'd0, 32'h04, "t2_pending");
        rd(2'd2, 32'h8000_0003, "t2_claim");
        expect_ext(1'b0, "t2_claimed_ext");
        rd(2'd3, 32'h0000_0302, "t2_status");
        wr(2'd2, 32'd3);
        rd(2'd3, 32'd0, "t2_idle");

        // 3/4: priority, wrong complete ignored, re-assert after complete
        wr(2'd1, 32'hFF);
        I_irq = 8'h22; tick(); I_irq = 8'h00; tick();
        expect_ext(1'b1, "t3_ext");
        rd(2'd2, 32'h8000_0002, "t3_claim2");
        rd(2'd0, 32'h20, "t3_pending");
        wr(2'd2, 32'd5);
        rd(2'd3, 32'h0000_0202, "t4_bad_complete");
        wr(2'd2, 32'd2);
        expect_ext(1'b0, "t3_after_complete");
        tick();
        expect_ext(1'b1, "t3_reassert");
        rd(2'd2, 32'h8000_0006, "t3_claim6");
        wr(2'd2, 32'd6);

        // 5: masked pending, enable late, disable while signalling
        wr(2'd1, 32'h00);
        I_irq = 8'h08; tick(); I_irq = 8'h00; tick();
        expect_ext(1'b0, "t5_masked");
        rd(2'd0, 32'h08, "t5_pending");
        wr(2'd1, 32'h08);
        tick();
        expect_ext(1'b1, "t5_enabled");
        wr(2'd1, 32'h00);
        tick();
        expect_ext(1'b0, "t5_disabled");
        rd(2'd0, 32'h08, "t5_pending_kept");

        // 6: reset while claimed with work pending; held level does not re-pend
        wr(2'd1, 32'h08);
        tick();
        rd(2'd2, 32'h8000_0004, "t6_claim4");
        I_irq = 8'h01; tick();
        I_irq = 8'h80; tick();
        rd(2'd0, 32'h81, "t6_pending");
        rd(2'd3, 32'h0000_0402, "t6_status");
        I_rst = 1'b1; tick(); I_rst = 1'b0;
        expect_ext(1'b0, "t6_rst_ext");
        rd(2'd0, 32'd0, "t6_rst_pending");
        rd(2'd1, 32'd0, "t6_rst_enable");
        rd(2'd3, 32'd0, "t6_rst_status");
        tick();
        rd(2'd0, 32'd0, "t6_held_no_pend");
        I_irq = 8'h00; tick();
        I_irq = 8'h80; tick();
        rd(2'd0, 32'h80, "t6_repend");

        // Edge coinciding with claim keeps pending; simultaneous read+write on claim port
        wr(2'd1, 32'h80);
        I_irq = 8'h00; tick();
        I_irq = 8'h80;
        rd(2'd2, 32'h8000_0008, "sw_claim8");
        rd(2'd0, 32'h80, "sw_set_wins");
        I_addr = 2'd2; I_ren = 1'b1; I_wen = 1'b1; I_wdata = 32'd8;
        #1 chk("rw_claim_rdata", O_rdata, 32'd0);
        tick();
        I_ren = 1'b0; I_wen = 1'b0;
        rd(2'd3, 32'h0000_0802, "rw_write_ignored");
        wr(2'd2, 32'd8);
        tick();
        expect_ext(1'b1, "sw_reassert");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
